tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note-table tone sequencer: steps through 16 entries, driving a tone generator for duration*TICK_DIV clocks each.
// Optional macro TONE_SEQ_GAP_EN adds a one-tick silent GAP state after every note.
module tone_sequencer #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [15:0] volume_in,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [30:0] wr_data,
    output logic        gen_enable,
    output logic [20:0] gen_full_period,
    output logic [20:0] gen_active_period,
    output logic [15:0] gen_volume,
    output logic        busy,
    output logic        done,
    output logic [3:0]  note_idx
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

`ifdef TONE_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  note_idx_q, note_idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]  dur_cnt_q, dur_cnt_d;
    logic        gen_enable_q, gen_enable_d;
    logic [20:0] full_period_q, full_period_d;
    logic [20:0] active_period_q, active_period_d;
    logic [15:0] volume_q, volume_d;
    logic        done_q, done_d;

    logic [30:0] note_table [16];
    logic [30:0] entry;
    logic [20:0] entry_period;
    logic [1:0]  entry_duty;
    logic [7:0]  entry_dur;
    logic [20:0] entry_active;
    logic        tick_last;
    logic        advance;
    logic        seq_end;

    // Table contents survive reset; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            note_table[wr_addr] <= wr_data;
        end
    end

    // The table cannot change outside IDLE, so the live entry stays valid for the whole note.
    assign entry        = note_table[note_idx_q];
    assign entry_period = entry[30:10];
    assign entry_duty   = entry[9:8];
    assign entry_dur    = entry[7:0];
    assign tick_last    = (presc_q == PRESC_MAX);

    always_comb begin
        case (entry_duty)
            2'b00:   entry_active = entry_period >> 3;
            2'b01:   entry_active = entry_period >> 2;
            2'b10:   entry_active = entry_period >> 1;
            default: entry_active = entry_period - (entry_period >> 2);
        endcase
    end

    always_comb begin
        state_d         = state_q;
        note_idx_d      = note_idx_q;
        presc_d         = presc_q;
        dur_cnt_d       = dur_cnt_q;
        gen_enable_d    = gen_enable_q;
        full_period_d   = full_period_q;
        active_period_d = active_period_q;
        volume_d        = volume_in;
        done_d          = 1'b0;
        advance         = 1'b0;
        seq_end         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    note_idx_d = 4'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (entry_dur == 8'd0) begin
                    seq_end = 1'b1;
                end else begin
                    state_d         = PLAY;
                    presc_d         = '0;
                    dur_cnt_d       = 8'd0;
                    full_period_d   = entry_period;
                    active_period_d = entry_active;
                    gen_enable_d    = (entry_period != 21'd0);
                end
            end
            PLAY: begin
                presc_d = tick_last ? '0 : presc_q + PW'(1);
                if (tick_last) begin
                    dur_cnt_d = dur_cnt_q + 8'd1;
                end
                if (tick_last && dur_cnt_q == entry_dur - 8'd1) begin
                    gen_enable_d = 1'b0;
`ifdef TONE_SEQ_GAP_EN
                    state_d = GAP;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP: begin
                presc_d = tick_last ? '0 : presc_q + PW'(1);
                if (tick_last) begin
                    advance = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (note_idx_q == 4'd15) begin
                seq_end = 1'b1;
            end else begin
                note_idx_d = note_idx_q + 4'd1;
                state_d    = LOAD;
            end
        end

        // A marker at entry 0 must always finish, otherwise loop would spin forever on an empty table.
        if (seq_end) begin
            if (loop && note_idx_q != 4'd0) begin
                note_idx_d = 4'd0;
                state_d    = LOAD;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (stop) begin
            state_d      = IDLE;
            gen_enable_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            note_idx_q      <= 4'd0;
            presc_q         <= '0;
            dur_cnt_q       <= 8'd0;
            gen_enable_q    <= 1'b0;
            full_period_q   <= 21'd0;
            active_period_q <= 21'd0;
            volume_q        <= 16'd0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            note_idx_q      <= note_idx_d;
            presc_q         <= presc_d;
            dur_cnt_q       <= dur_cnt_d;
            gen_enable_q    <= gen_enable_d;
            full_period_q   <= full_period_d;
            active_period_q <= active_period_d;
            volume_q        <= volume_d;
            done_q          <= done_d;
        end
    end

    assign gen_enable        = gen_enable_q;
    assign gen_full_period   = full_period_q;
    assign gen_active_period = active_period_q;
    assign gen_volume        = volume_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign note_idx          = note_idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized self-checking bench for tone_sequencer (TICK_DIV=4) against a cycle-trace model built from the note table.
// Honours TONE_SEQ_GAP_EN when the design is built with it.
module tb_tone_sequencer;

    localparam int TICK = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        loop      = 1'b0;
    logic [15:0] volume_in = 16'd0;
    logic        wr_en     = 1'b0;
    logic [3:0]  wr_addr   = 4'd0;
    logic [30:0] wr_data   = 31'd0;
    logic        gen_enable;
    logic [20:0] gen_full_period;
    logic [20:0] gen_active_period;
    logic [15:0] gen_volume;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    typedef struct {
        bit busy;
        bit done;
        bit en;
        bit play;
        int idx;
        int fp;
        int ap;
    } exp_t;

    exp_t        exp_q[$];
    logic [30:0] model_tbl [16];
    logic [15:0] exp_vol = 16'd0;
    int          errors  = 0;
    int          checks  = 0;

    always #5 clk = ~clk;

    tone_sequencer #(.TICK_DIV(TICK)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .stop              (stop),
        .loop              (loop),
        .volume_in         (volume_in),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .gen_enable        (gen_enable),
        .gen_full_period   (gen_full_period),
        .gen_active_period (gen_active_period),
        .gen_volume        (gen_volume),
        .busy              (busy),
        .done              (done),
        .note_idx          (note_idx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [30:0] mk(input int p, input int duty, input int dur);
        return {21'(p), 2'(duty), 8'(dur)};
    endfunction

    function automatic int expected_active(input int p, input int duty);
        case (duty)
            0:       return p / 8;
            1:       return p / 4;
            2:       return p / 2;
            default: return p - p / 4;
        endcase
    endfunction

    function automatic void push(input bit b, input bit d, input bit e, input bit pl,
                                 input int i, input int f, input int a);
        exp_t x;
        x.busy = b; x.done = d; x.en = e; x.play = pl; x.idx = i; x.fp = f; x.ap = a;
        exp_q.push_back(x);
    endfunction

    // Expected state for every clock after the start pulse, derived note by note from the table.
    function automatic void build_trace(input bit lp, input int max_len);
        int idx = 0;
        int p;
        int dur;
        int ap;
        bit fin;
        exp_q.delete();
        while (exp_q.size() < max_len) begin
            push(1, 0, 0, 0, idx, 0, 0);
            p   = int'(model_tbl[idx][30:10]);
            dur = int'(model_tbl[idx][7:0]);
            fin = (dur == 0);
            if (!fin) begin
                ap = expected_active(p, int'(model_tbl[idx][9:8]));
                for (int c = 0; c < dur * TICK; c++) push(1, 0, p != 0, 1, idx, p, ap);
`ifdef TONE_SEQ_GAP_EN
                for (int c = 0; c < TICK; c++) push(1, 0, 0, 0, idx, 0, 0);
`endif
                fin = (idx == 15);
                if (!fin) idx++;
            end
            if (fin) begin
                if (lp && idx != 0) begin
                    idx = 0;
                end else begin
                    push(0, 1, 0, 0, idx, 0, 0);
                    push(0, 0, 0, 0, idx, 0, 0);
                    break;
                end
            end
        end
        while (exp_q.size() > max_len) void'(exp_q.pop_back());
    endfunction

    task automatic step();
        exp_vol = volume_in;
        @(negedge clk);
        volume_in = 16'($urandom);
    endtask

    task automatic write_table();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = model_tbl[i];
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) model_tbl[i] = mk(0, 0, 0);
    endtask

    // Start a run, compare every clock against the trace, and abort with stop if still busy at the end.
    task automatic applyStimulus(input bit lp, input int max_len, input bit noise);
        exp_t e;
        build_trace(lp, max_len);
        loop  = lp;
        start = 1'b1;
        foreach (exp_q[k]) begin
            step();
            start = 1'b0;
            wr_en = 1'b0;
            e = exp_q[k];
            checkOutput($sformatf("busy@%0d", k), busy, e.busy);
            checkOutput($sformatf("done@%0d", k), done, e.done);
            checkOutput($sformatf("gen_enable@%0d", k), gen_enable, e.en);
            checkOutput($sformatf("note_idx@%0d", k), note_idx, e.idx);
            checkOutput($sformatf("gen_volume@%0d", k), gen_volume, exp_vol);
            if (e.play) begin
                checkOutput($sformatf("full_period@%0d", k), gen_full_period, e.fp);
                checkOutput($sformatf("active_period@%0d", k), gen_active_period, e.ap);
            end
            if (noise && e.busy) begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = 4'($urandom);
                wr_data = 31'($urandom);
                start   = ($urandom_range(0, 7) == 0);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (exp_q.size() > 0 && exp_q[exp_q.size() - 1].busy) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_gen_enable", gen_enable, 0);
            checkOutput("stop_done", done, 0);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_gen_enable", gen_enable, 0);
        checkOutput("rst_note_idx", note_idx, 0);
        checkOutput("rst_full_period", gen_full_period, 0);
        checkOutput("rst_active_period", gen_active_period, 0);
        checkOutput("rst_gen_volume", gen_volume, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        clear_table();
        model_tbl[0] = mk(100, 2, 3);
        write_table();
        applyStimulus(0, 1000, 0);

        clear_table();
        model_tbl[0] = mk(1000, 0, 1);
        model_tbl[1] = mk(1000, 1, 1);
        model_tbl[2] = mk(1000, 3, 1);
        write_table();
        applyStimulus(0, 1000, 1);

        clear_table();
        model_tbl[0] = mk(300, 1, 1);
        model_tbl[1] = mk(500, 2, 2);
        write_table();
        applyStimulus(1, 40, 1);
        applyStimulus(0, 1000, 0);

        clear_table();
        model_tbl[0] = mk(0, 0, 2);
        model_tbl[1] = mk(800, 3, 1);
        write_table();
        applyStimulus(0, 1000, 1);

        clear_table();
        write_table();
        applyStimulus(1, 1000, 0);

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("start_stop_busy", busy, 0);
        step();
        checkOutput("start_stop_busy_late", busy, 0);

        clear_table();
        model_tbl[0] = mk(100, 2, 3);
        write_table();
        loop  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checkOutput("pre_rst_gen_enable", gen_enable, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_gen_enable", gen_enable, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_note_idx", note_idx, 0);
        checkOutput("mid_rst_full_period", gen_full_period, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        applyStimulus(0, 1000, 0);

        for (int r = 0; r < 25; r++) begin
            int m;
            for (int i = 0; i < 16; i++) begin
                model_tbl[i] = mk(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 21'h1FFFFF)),
                                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            end
            m = int'($urandom_range(0, 19));
            if (m < 16) model_tbl[m][7:0] = 8'd0;
            write_table();
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(10, 400)), 1'b1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
